// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// R-type function codes and the ALU operation selects the ALU also decodes.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_MUL  = 6'b011000;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0100;
  localparam logic [3:0] ALU_SRA  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLLV = 4'b1000;
  localparam logic [3:0] ALU_SRLV = 4'b1001;
  localparam logic [3:0] ALU_SRAV = 4'b1010;
  localparam logic [3:0] ALU_MUL  = 4'b1011;

endpackage

// File: rtl/alu_decoder.sv
// R-type function field decode: maps Funct to an ALU operation select and
// flags whether the function code is one the datapath implements.
module alu_decoder
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_sel,
  output logic       valid
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    alu_sel = ALU_ADD;
    valid   = 1'b1;
    case (funct)
      FN_ADD:  alu_sel = ALU_ADD;
      FN_SUB:  alu_sel = ALU_SUB;
      FN_AND:  alu_sel = ALU_AND;
      FN_OR:   alu_sel = ALU_OR;
      FN_SLT:  alu_sel = ALU_SLT;
      FN_SLL:  alu_sel = ALU_SLL;
      FN_SRL:  alu_sel = ALU_SRL;
      FN_SRA:  alu_sel = ALU_SRA;
      FN_SLLV: alu_sel = ALU_SLLV;
      FN_SRLV: alu_sel = ALU_SRLV;
      FN_SRAV: alu_sel = ALU_SRAV;
      FN_MUL:  alu_sel = ALU_MUL;
      default: valid   = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, with datapath selects decoded from the current state.
module mc_control
  import mc_pkg::*;
#(
  parameter int SEL = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [5:0]     Opcode,
  input  logic [5:0]     Funct,
  input  logic           Zero,
  output logic           PCEn,
  output logic           IorD,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           RegDst,
  output logic           MemtoReg,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [SEL-1:0] ALUsel,
  output logic [1:0]     PCSrc,
  output logic [3:0]     State
);

  state_t     state_q, state_d, view;
  logic [3:0] fn_sel;
  logic       fn_valid;

  alu_decoder u_alu_decoder (
    .funct   (Funct),
    .alu_sel (fn_sel),
    .valid   (fn_valid)
  );

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  assign State = state_q;

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_R:           state_d = S_EXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDIEX;
          OP_J:           state_d = S_JUMP;
          default:        state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = fn_valid ? S_ALUWB : S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Under reset the datapath sees the FETCH selects; enables are masked below.
  assign view = rst ? state_q : S_FETCH;

  always_comb begin
    PCEn     = 1'b0;
    IorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUsel   = SEL'(ALU_ADD);
    PCSrc    = 2'b00;
    case (view)
      S_FETCH: begin
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCEn    = 1'b1;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUsel  = SEL'(fn_sel);
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUsel  = SEL'(ALU_SUB);
        PCSrc   = 2'b01;
        PCEn    = (Opcode == OP_BNE) ? ~Zero : Zero;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
      default: ;
    endcase
    if (!rst) begin
      PCEn     = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: the driver pushes the hand-derived output
// vector for each cycle, the monitor pops and compares on the falling edge.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Opcode, Funct;
  logic       Zero;
  logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] ALUsel, State;

  mc_control #(.SEL(4)) dut (
    .clk(clk), .rst(rst), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .PCEn(PCEn), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUsel(ALUsel), .PCSrc(PCSrc),
    .State(State)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] state;
    logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic [3:0] alusel;
    logic [1:0] pcsrc;
  } vec_t;

  typedef struct {
    string name;
    vec_t  v;
  } item_t;

  item_t sb[$];
  int    tests = 0;
  int    fails = 0;

  // Expected outputs for one cycle, written out state by state from the control table.
  function automatic vec_t exp_of(int st, logic [5:0] op, logic z, logic rstv, logic [3:0] xsel);
    vec_t e;
    e = '0;
    e.state  = 4'(st);
    e.alusel = 4'b0010;
    if (!rstv) begin
      e.alusrcb = 2'b01;
      return e;
    end
    case (st)
      0:  begin e.irwrite = 1; e.alusrcb = 2'b01; e.pcen = 1; end
      1:  e.alusrcb = 2'b11;
      2:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      3:  e.iord = 1;
      4:  begin e.memtoreg = 1; e.regwrite = 1; end
      5:  begin e.iord = 1; e.memwrite = 1; end
      6:  begin e.alusrca = 1; e.alusel = xsel; end
      7:  begin e.regdst = 1; e.regwrite = 1; end
      8:  begin e.alusrca = 1; e.alusel = 4'b0110; e.pcsrc = 2'b01;
                e.pcen = (op == 6'b000101) ? ~z : z; end
      9:  begin e.alusrca = 1; e.alusrcb = 2'b10; end
      10: e.regwrite = 1;
      11: begin e.pcsrc = 2'b10; e.pcen = 1; end
      default: ;
    endcase
    return e;
  endfunction

  // Push this cycle's expectation, then advance to just after the next rising edge.
  task automatic step(input string nm, input int st, input logic [3:0] xsel);
    item_t it;
    it.name = $sformatf("%s/s%0d", nm, st);
    it.v    = exp_of(st, Opcode, Zero, rst, xsel);
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                           input logic z, input int n, input int s0, input int s1,
                           input int s2, input int s3, input int s4, input logic [3:0] xsel);
    int seq[5];
    seq = '{s0, s1, s2, s3, s4};
    Opcode = op;
    Funct  = fn;
    Zero   = z;
    for (int i = 0; i < n; i++) step(nm, seq[i], xsel);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      item_t it;
      vec_t  act;
      it  = sb.pop_front();
      act = '{State, PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
              ALUSrcA, ALUSrcB, ALUsel, PCSrc};
      tests++;
      if (act !== it.v) begin
        fails++;
        $display("FAIL %s: got %h want %h (state,pcen,iord,memwr,irwr,regdst,memtoreg,regwr,srca,srcb,alusel,pcsrc)",
                 it.name, act, it.v);
      end
    end
  end

  initial begin
    rst = 1'b0; Opcode = 6'b111111; Funct = 6'b000000; Zero = 1'b1;
    @(posedge clk);
    #1;
    step("reset0", 0, 4'b0010);
    Opcode = 6'b100011;
    step("reset1", 0, 4'b0010);
    rst = 1'b1;

    run_instr("sub",   6'b000000, 6'b100010, 0, 4, 0, 1, 6, 7, 0, 4'b0110);
    run_instr("add",   6'b000000, 6'b100000, 0, 4, 0, 1, 6, 7, 0, 4'b0010);
    run_instr("mul",   6'b000000, 6'b011000, 0, 4, 0, 1, 6, 7, 0, 4'b1011);
    run_instr("sllv",  6'b000000, 6'b000100, 0, 4, 0, 1, 6, 7, 0, 4'b1000);
    run_instr("sra",   6'b000000, 6'b000011, 0, 4, 0, 1, 6, 7, 0, 4'b0101);
    run_instr("lw",    6'b100011, 6'b000000, 0, 5, 0, 1, 2, 3, 4, 4'b0010);
    run_instr("sw",    6'b101011, 6'b000000, 0, 4, 0, 1, 2, 5, 0, 4'b0010);
    run_instr("addi",  6'b001000, 6'b000000, 0, 4, 0, 1, 9, 10, 0, 4'b0010);
    run_instr("j",     6'b000010, 6'b000000, 0, 3, 0, 1, 11, 0, 0, 4'b0010);
    run_instr("beq_z1", 6'b000100, 6'b000000, 1, 3, 0, 1, 8, 0, 0, 4'b0010);
    run_instr("beq_z0", 6'b000100, 6'b000000, 0, 3, 0, 1, 8, 0, 0, 4'b0010);
    run_instr("bne_z1", 6'b000101, 6'b000000, 1, 3, 0, 1, 8, 0, 0, 4'b0010);
    run_instr("bne_z0", 6'b000101, 6'b000000, 0, 3, 0, 1, 8, 0, 0, 4'b0010);
    run_instr("badop", 6'b111111, 6'b000000, 0, 2, 0, 1, 0, 0, 0, 4'b0010);
    run_instr("badfn", 6'b000000, 6'b111111, 0, 3, 0, 1, 6, 0, 0, 4'b0010);

    // Reset arriving while a store is in its write cycle.
    run_instr("sw_abort", 6'b101011, 6'b000000, 0, 3, 0, 1, 2, 0, 0, 4'b0010);
    rst = 1'b0;
    step("sw_abort", 5, 4'b0010);
    rst = 1'b1;
    run_instr("after_abort", 6'b000010, 6'b000000, 0, 3, 0, 1, 11, 0, 0, 4'b0010);

    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
